serial_adder_ctrl: RTL and testbench



---
 rtl/serial_arith_pkg.sv | 10 +
 rtl/serial_adder_ctrl_if.sv | 24 ++
 rtl/serial_adder_ctrl_fa.sv | 11 +
 rtl/serial_adder_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
package serial_arith_pkg;
  localparam int SERIAL_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle for serial_adder_ctrl.
// The sub signal exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = serial_arith_pkg::SERIAL_WIDTH_DEFAULT
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output start, a, b, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, input busy, done, sum, cout);
  modport slave  (input start, a, b, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_ctrl_fa.sv
// One-bit full-adder cell shared by the serial arithmetic blocks.
module Full_adder (
  output logic S,
  output logic Cout,
  input  logic A,
  input  logic B,
  input  logic Cin
);
  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one Full_adder cell stepped LSB-first, WIDTH cycles per op.
// Optional subtract mode under SERIAL_ADD_SUB_EN.
module serial_adder_ctrl
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_s, fa_co, sub_w;
  logic [WIDTH-1:0] s_next;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_w = bus.sub;
`else
  assign sub_w = 1'b0;
`endif

  Full_adder u_fa (
    .S   (fa_s),
    .Cout(fa_co),
    .A   (a_sr_q[0]),
    .B   (b_sr_q[0]),
    .Cin (carry_q)
  );

  // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH steps.
  assign s_next = {fa_s, s_sr_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = sub_w ? ~bus.b : bus.b;
          carry_d = sub_w;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
        s_sr_d  = s_next;
        carry_d = fa_co;
        if (cnt_q == LAST) begin
          sum_d   = s_next;
          cout_d  = fa_co;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench: directed WIDTH=8 vectors plus WIDTH=2/32 continuous-start sweeps.
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  serial_adder_ctrl_if #(.WIDTH(8))  b8 ();
  serial_adder_ctrl_if #(.WIDTH(2))  b2 ();
  serial_adder_ctrl_if #(.WIDTH(32)) b32 ();

  serial_adder_ctrl #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(b8));
  serial_adder_ctrl #(.WIDTH(2))  u2  (.clk(clk), .rst(rst), .bus(b2));
  serial_adder_ctrl #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(b32));

  int          q8_t[$];
  logic [8:0]  q8_v[$];
  logic [2:0]  q2_v[$];
  logic [32:0] q32_v[$];
  int          last2 = -1;
  int          last32 = -1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: done with no outstanding request (cycle %0d)", nm, cyc);
  endtask

  // Drive one start cycle on the WIDTH=8 DUT; result expected 9 cycles on.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic push, input logic [8:0] e);
    b8.start = 1'b1;
    b8.a     = a;
    b8.b     = b;
`ifdef SERIAL_ADD_SUB_EN
    b8.sub   = s;
`else
    if (s) $display("note: subtract request ignored in add-only build");
`endif
    if (push) begin
      q8_t.push_back(cyc + 9);
      q8_v.push_back(e);
    end
    @(posedge clk); #1;
    b8.start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && b8.done) begin
      if (q8_v.size() == 0) unexpected("w8 done");
      else begin
        chk("w8 latency", 64'(cyc), 64'(q8_t.pop_front()));
        chk("w8 result", {55'd0, b8.cout, b8.sum}, {55'd0, q8_v.pop_front()});
        chk("w8 busy in done", {63'd0, b8.busy}, 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b2.done) begin
      if (q2_v.size() == 0) unexpected("w2 done");
      else chk("w2 result", {61'd0, b2.cout, b2.sum}, {61'd0, q2_v.pop_front()});
      if (last2 >= 0) chk("w2 period", 64'(cyc - last2), 64'd3);
      last2 = cyc;
    end
  end

  always @(negedge clk) begin
    if (!rst && b32.done) begin
      if (q32_v.size() == 0) unexpected("w32 done");
      else chk("w32 result", {31'd0, b32.cout, b32.sum}, {31'd0, q32_v.pop_front()});
      if (last32 >= 0) chk("w32 period", 64'(cyc - last32), 64'd33);
      last32 = cyc;
    end
  end

  task automatic sweep2();
    int cnt = 0;
    int g = 0;
    logic [1:0] x, y;
    x = 2'($urandom_range(3)); y = 2'($urandom_range(3));
    b2.a = x; b2.b = y;
    q2_v.push_back({1'b0, x} + {1'b0, y});
    b2.start = 1'b1;
    while (cnt < 200 && g < 20000) begin
      @(negedge clk); g++;
      if (b2.done) begin
        cnt++;
        if (cnt < 200) begin
          x = 2'($urandom_range(3)); y = 2'($urandom_range(3));
          b2.a = x; b2.b = y;
          q2_v.push_back({1'b0, x} + {1'b0, y});
        end else b2.start = 1'b0;
      end
    end
    if (cnt < 200) begin
      n_chk++; n_fail++;
      $display("FAIL w2 sweep timeout: got %0d ops expected 200", cnt);
    end
  endtask

  task automatic sweep32();
    int cnt = 0;
    int g = 0;
    logic [31:0] x, y;
    x = $urandom; y = $urandom;
    b32.a = x; b32.b = y;
    q32_v.push_back({1'b0, x} + {1'b0, y});
    b32.start = 1'b1;
    while (cnt < 200 && g < 20000) begin
      @(negedge clk); g++;
      if (b32.done) begin
        cnt++;
        if (cnt < 200) begin
          x = $urandom; y = $urandom;
          b32.a = x; b32.b = y;
          q32_v.push_back({1'b0, x} + {1'b0, y});
        end else b32.start = 1'b0;
      end
    end
    if (cnt < 200) begin
      n_chk++; n_fail++;
      $display("FAIL w32 sweep timeout: got %0d ops expected 200", cnt);
    end
  endtask

  initial begin
    int nb;
    b8.start = 0; b8.a = 0; b8.b = 0;
    b2.start = 0; b2.a = 0; b2.b = 0;
    b32.start = 0; b32.a = 0; b32.b = 0;
`ifdef SERIAL_ADD_SUB_EN
    b8.sub = 0; b2.sub = 0; b32.sub = 0;
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", {63'd0, b8.busy}, 64'd0);
    chk("reset done", {63'd0, b8.done}, 64'd0);
    chk("reset sum/cout", {55'd0, b8.cout, b8.sum}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Abandoned operation: reset mid-RUN, no done may follow.
    issue8(8'hFF, 8'h01, 1'b0, 1'b0, 9'h0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrun reset busy", {63'd0, b8.busy}, 64'd0);
    chk("midrun reset done", {63'd0, b8.done}, 64'd0);
    chk("midrun reset sum/cout", {55'd0, b8.cout, b8.sum}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(posedge clk); #1;

    // Basic add with busy-length check.
    issue8(8'h35, 8'h4A, 1'b0, 1'b1, {1'b0, 8'h7F});
    nb = 0;
    repeat (10) begin
      @(negedge clk); nb += int'(b8.busy);
      @(posedge clk); #1;
    end
    chk("busy cycles", 64'(nb), 64'd8);

    // Carry chain; result must hold through idle.
    issue8(8'hFF, 8'h01, 1'b0, 1'b1, {1'b1, 8'h00});
    repeat (9) @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("hold after done", {55'd0, b8.cout, b8.sum}, 64'h100);
    end
    @(posedge clk); #1;

    // Start during RUN is ignored; start in DONE is accepted.
    issue8(8'h12, 8'h34, 1'b0, 1'b1, {1'b0, 8'h46});
    repeat (2) @(posedge clk); #1;
    issue8(8'h01, 8'h01, 1'b0, 1'b0, 9'h0);
    repeat (5) @(posedge clk); #1;
    issue8(8'h80, 8'h80, 1'b0, 1'b1, {1'b1, 8'h00});
    repeat (12) @(posedge clk); #1;

`ifdef SERIAL_ADD_SUB_EN
    issue8(8'h10, 8'h03, 1'b1, 1'b1, {1'b1, 8'h0D});
    repeat (12) @(posedge clk); #1;
    issue8(8'h03, 8'h10, 1'b1, 1'b1, {1'b0, 8'hF3});
    repeat (12) @(posedge clk); #1;
`endif

    fork
      sweep2();
      sweep32();
    join
    repeat (4) @(posedge clk); #1;

    chk("w8 queue drained", 64'(q8_v.size()), 64'd0);
    chk("w2 queue drained", 64'(q2_v.size()), 64'd0);
    chk("w32 queue drained", 64'(q32_v.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
